// File: rtl/fminmax_reduce.sv
// Floating-point min/max reduction over a stream of len operands.
// NaN operands are skipped; an all-NaN stream yields the canonical quiet NaN.
module fminmax_reduce #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [CNT_W-1:0]     len_i,
  output logic                 busy_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [EXP_W+MAN_W:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [EXP_W+MAN_W:0] out_data_o,
  output logic                 out_nv_o
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;

  state_e           state_q;
  logic             busy_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             mode_q;
  logic             nv_q;
  logic             out_nv_q;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     out_data_q;
  logic [CNT_W-1:0] rem_q;

  logic             acc_nan;
  logic             in_nan;
  logic             in_snan;
  logic             same;
  logic             acc_lt_in;
  logic             take_in;
  logic             nv_d;
  logic [W-1:0]     acc_d;
  logic [CNT_W-1:0] rem_d;

  always_comb begin
    acc_nan = (&acc_q[W-2:MAN_W]) && (|acc_q[MAN_W-1:0]);
    in_nan  = (&in_data_i[W-2:MAN_W]) && (|in_data_i[MAN_W-1:0]);
    in_snan = in_nan && !in_data_i[MAN_W-1];
    same    = (acc_q == in_data_i);
    // Sign-magnitude order: differing signs decide alone, so -0 < +0.
    if (acc_q[W-1] != in_data_i[W-1]) begin
      acc_lt_in = acc_q[W-1];
    end else if (!acc_q[W-1]) begin
      acc_lt_in = (acc_q[W-2:0] < in_data_i[W-2:0]);
    end else begin
      acc_lt_in = (acc_q[W-2:0] > in_data_i[W-2:0]);
    end
    take_in = mode_q ? acc_lt_in : (!acc_lt_in && !same);
    if (acc_nan && in_nan) begin
      acc_d = CANON_NAN;
    end else if (acc_nan) begin
      acc_d = in_data_i;
    end else if (in_nan) begin
      acc_d = acc_q;
    end else begin
      acc_d = take_in ? in_data_i : acc_q;
    end
    nv_d  = nv_q | in_snan;
    rem_d = rem_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      nv_q        <= 1'b0;
      out_nv_q    <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            acc_q  <= CANON_NAN;
            nv_q   <= 1'b0;
            mode_q <= mode_i;
            rem_q  <= len_i;
            busy_q <= 1'b1;
            if (len_i != '0) begin
              state_q    <= S_ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= CANON_NAN;
              out_nv_q    <= 1'b0;
            end
          end
        end
        S_ACCUM: begin
          if (in_valid_i) begin
            acc_q <= acc_d;
            nv_q  <= nv_d;
            rem_q <= rem_d;
            if (rem_q == CNT_W'(1)) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= acc_d;
              out_nv_q    <= nv_d;
            end
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_nv_o    = out_nv_q;

endmodule

// File: tb/tb_fminmax_reduce.sv
// Scoreboard bench for fminmax_reduce: FP32 and FP16 instances on one clock.
module tb_fminmax_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_start, s_mode, s_in_valid, s_out_ready;
  logic [7:0]  s_len;
  logic [31:0] s_in_data;
  logic        busy, in_ready, out_valid, out_nv;
  logic [31:0] out_data;

  logic        h_start, h_mode, h_in_valid, h_out_ready;
  logic [7:0]  h_len;
  logic [15:0] h_in_data;
  logic        h_busy, h_in_ready, h_out_valid, h_out_nv;
  logic [15:0] h_out_data;

  fminmax_reduce #(.EXP_W(8), .MAN_W(23), .CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .mode_i(s_mode), .len_i(s_len),
    .busy_o(busy), .in_valid_i(s_in_valid), .in_ready_o(in_ready), .in_data_i(s_in_data),
    .out_valid_o(out_valid), .out_ready_i(s_out_ready), .out_data_o(out_data), .out_nv_o(out_nv)
  );

  fminmax_reduce #(.EXP_W(5), .MAN_W(10), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(h_start), .mode_i(h_mode), .len_i(h_len),
    .busy_o(h_busy), .in_valid_i(h_in_valid), .in_ready_o(h_in_ready), .in_data_i(h_in_data),
    .out_valid_o(h_out_valid), .out_ready_i(h_out_ready), .out_data_o(h_out_data), .out_nv_o(h_out_nv)
  );

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  logic [16:0] h_exp_q[$];
  logic [31:0] el_q[$];
  int          gp_q[$];

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && s_out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out32", {32'b0, out_valid}, 33'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("out_data32", {1'b0, out_data}, {1'b0, e[31:0]});
        check("out_nv32", {32'b0, out_nv}, {32'b0, e[32]});
      end
    end
    if (h_out_valid && h_out_ready) begin
      if (h_exp_q.size() == 0) begin
        check("spurious_out16", {32'b0, h_out_valid}, 33'd0);
      end else begin
        logic [16:0] e;
        e = h_exp_q.pop_front();
        check("out_data16", {17'b0, h_out_data}, {17'b0, e[15:0]});
        check("out_nv16", {32'b0, h_out_nv}, {32'b0, e[16]});
      end
    end
  end

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Total-order key: negative values bit-inverted, positive values offset above them.
  function automatic logic [31:0] okey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] mop(input logic m, input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) && is_nan(b)) return 32'h7FC0_0000;
    if (is_nan(a)) return b;
    if (is_nan(b)) return a;
    if (m) return (okey(b) > okey(a)) ? b : a;
    return (okey(b) < okey(a)) ? b : a;
  endfunction

  task automatic add(input logic [31:0] d, input int g);
    el_q.push_back(d);
    gp_q.push_back(g);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100; t++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("idle_timeout", {32'b0, busy}, 33'd0);
  endtask

  // Entered and left 1 time unit after a rising edge; consumes el_q/gp_q.
  task automatic run32(input logic m, input logic [32:0] expv);
    int n;
    n = el_q.size();
    exp_q.push_back(expv);
    s_start = 1'b1; s_mode = m; s_len = 8'(n);
    @(posedge clk); #1;
    s_start = 1'b0; s_mode = ~m; s_len = 8'hFF;
    check("busy_after_start", {32'b0, busy}, 33'd1);
    check("ready_after_start", {32'b0, in_ready}, {32'b0, (n != 0)});
    for (int i = 0; i < n; i++) begin
      s_in_valid = 1'b0;
      for (int g = 0; g < gp_q[i]; g++) begin
        @(posedge clk); #1;
      end
      s_in_valid = 1'b1;
      s_in_data  = el_q[i];
      check("in_ready", {32'b0, in_ready}, 33'd1);
      if (i == n - 1) check("ov_before_last", {32'b0, out_valid}, 33'd0);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    s_in_data  = $urandom;
    check("ov_after_last", {32'b0, out_valid}, 33'd1);
    check("ir_after_last", {32'b0, in_ready}, 33'd0);
    el_q.delete();
    gp_q.delete();
    wait_idle();
  endtask

  task automatic run16(input logic m, input logic [15:0] a, input logic [15:0] b, input logic [16:0] expv);
    h_exp_q.push_back(expv);
    h_start = 1'b1; h_mode = m; h_len = 8'd2;
    @(posedge clk); #1;
    h_start = 1'b0; h_mode = ~m;
    h_in_valid = 1'b1; h_in_data = a;
    @(posedge clk); #1;
    h_in_data = b;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    check("ov16_after_last", {32'b0, h_out_valid}, 33'd1);
    for (int t = 0; t < 20; t++) begin
      if (!h_busy) break;
      @(posedge clk); #1;
    end
    check("idle16_timeout", {32'b0, h_busy}, 33'd0);
  endtask

  initial begin
    logic [31:0] pool [10];
    logic [31:0] acc;
    logic        nv, m;
    int          n;

    rst_n = 1'b0;
    s_start = 0; s_mode = 0; s_len = 0; s_in_valid = 0; s_in_data = 0; s_out_ready = 1;
    h_start = 0; h_mode = 0; h_len = 0; h_in_valid = 0; h_in_data = 0; h_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {32'b0, busy}, 33'd0);
    check("rst_in_ready", {32'b0, in_ready}, 33'd0);
    check("rst_out_valid", {32'b0, out_valid}, 33'd0);
    check("rst_out_data", {1'b0, out_data}, 33'd0);
    check("rst_out_nv", {32'b0, out_nv}, 33'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    add(32'h3F80_0000, 0); add(32'hC000_0000, 0); add(32'h4040_0000, 0); add(32'h0000_0000, 0);
    run32(1'b0, {1'b0, 32'hC000_0000});

    add(32'h8000_0000, 0); add(32'h0000_0000, 0); run32(1'b1, {1'b0, 32'h0000_0000});
    add(32'h8000_0000, 0); add(32'h0000_0000, 0); run32(1'b0, {1'b0, 32'h8000_0000});
    add(32'h0000_0000, 0); add(32'h8000_0000, 0); run32(1'b1, {1'b0, 32'h0000_0000});
    add(32'h0000_0000, 0); add(32'h8000_0000, 0); run32(1'b0, {1'b0, 32'h8000_0000});

    add(32'h7FC0_0000, 0); add(32'h7F80_0001, 0); add(32'h3F80_0000, 0);
    run32(1'b0, {1'b1, 32'h3F80_0000});
    add(32'hFFC1_2345, 0); add(32'h7FC0_0001, 0);
    run32(1'b0, {1'b0, 32'h7FC0_0000});

    add(32'hFF80_0000, 0); add(32'h7F80_0000, 2); add(32'h4200_0000, 1);
    run32(1'b1, {1'b0, 32'h7F80_0000});

    // len=0 with the result held off for five cycles and a stray start.
    s_out_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h7FC0_0000});
    s_start = 1'b1; s_mode = 1'b0; s_len = 8'd0;
    @(posedge clk); #1;
    s_start = 1'b0;
    check("len0_ov", {32'b0, out_valid}, 33'd1);
    for (int c = 0; c < 5; c++) begin
      check("stall_ov", {32'b0, out_valid}, 33'd1);
      check("stall_data", {1'b0, out_data}, {1'b0, 32'h7FC0_0000});
      check("stall_nv", {32'b0, out_nv}, 33'd0);
      check("stall_ir", {32'b0, in_ready}, 33'd0);
      if (c == 1) begin
        s_start = 1'b1; s_len = 8'd3; s_mode = 1'b1;
      end
      @(posedge clk); #1;
      s_start = 1'b0;
    end
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_ready", {32'b0, busy}, 33'd0);
    check("ov_after_ready", {32'b0, out_valid}, 33'd0);
    @(posedge clk); #1;
    check("idle_hold_data", {1'b0, out_data}, {1'b0, 32'h7FC0_0000});
    check("idle_stays", {32'b0, busy}, 33'd0);

    // Abort mid-stream by reset.
    s_start = 1'b1; s_mode = 1'b1; s_len = 8'd3;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_in_valid = 1'b1; s_in_data = 32'h3F80_0000;
    @(posedge clk); #1;
    s_in_data = 32'h4000_0000;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {32'b0, busy}, 33'd0);
    check("abort_in_ready", {32'b0, in_ready}, 33'd0);
    check("abort_out_valid", {32'b0, out_valid}, 33'd0);
    check("abort_out_data", {1'b0, out_data}, 33'd0);
    check("abort_out_nv", {32'b0, out_nv}, 33'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("post_abort_ov", {32'b0, out_valid}, 33'd0);
      check("post_abort_ir", {32'b0, in_ready}, 33'd0);
    end
    s_in_valid = 1'b0;

    // Randomised reductions against the total-order model.
    pool[0] = 32'h0000_0000; pool[1] = 32'h8000_0000; pool[2] = 32'h7F80_0000;
    pool[3] = 32'hFF80_0000; pool[4] = 32'h7FC0_0000; pool[5] = 32'h7F80_0001;
    pool[6] = 32'hFFC1_2345; pool[7] = 32'h3F80_0000; pool[8] = 32'hBF80_0000;
    for (int r = 0; r < 12; r++) begin
      n   = $urandom_range(1, 6);
      m   = 1'($urandom_range(0, 1));
      acc = 32'h7FC0_0000;
      nv  = 1'b0;
      for (int i = 0; i < n; i++) begin
        logic [31:0] d;
        pool[9] = $urandom;
        d = pool[$urandom_range(0, 9)];
        if (is_nan(d) && !d[22]) nv = 1'b1;
        acc = mop(m, acc, d);
        add(d, $urandom_range(0, 2));
      end
      run32(m, {nv, acc});
    end

    run16(1'b0, 16'h3C00, 16'hBC00, {1'b0, 16'hBC00});
    run16(1'b0, 16'h7C01, 16'hFE00, {1'b1, 16'h7E00});
    run16(1'b1, 16'h8000, 16'h0000, {1'b0, 16'h0000});

    repeat (2) @(posedge clk);
    #1;
    check("sb32_empty", 33'(exp_q.size()), 33'd0);
    check("sb16_empty", 33'(h_exp_q.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
